// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU command issuer.
package alu_pkg;

  // Command operation codes
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;

  // Function select encodings understood by the external ALU
  localparam logic [2:0] ALU_F_AND = 3'b000;
  localparam logic [2:0] ALU_F_OR  = 3'b001;
  localparam logic [2:0] ALU_F_ADD = 3'b010;
  localparam logic [2:0] ALU_F_SUB = 3'b110;
  localparam logic [2:0] ALU_F_SLT = 3'b111;

  // Issuer control states: idle, one-cycle execute, response hold
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Maps a command opcode to the ALU function select and flags unknown codes.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0] op,
  output logic [2:0] f,
  output logic       illegal
);

  // Pure lookup; unknown codes fall back to AND with the illegal flag raised
  always_comb begin
    f       = ALU_F_AND;
    illegal = 1'b0;
    unique case (op)
      OP_AND:  f = ALU_F_AND;
      OP_OR:   f = ALU_F_OR;
      OP_ADD:  f = ALU_F_ADD;
      OP_SUB:  f = ALU_F_SUB;
      OP_SLT:  f = ALU_F_SLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Accepts ALU commands, drives registered operands to an external ALU, and
// returns the captured result with the command tag over a valid/ready channel.
module alu_cmd_issuer
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [3:0]  cmd_tag,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_f,
  input  logic [31:0] alu_y,
  input  logic        alu_z,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_y,
  output logic        rsp_z,
  output logic [3:0]  rsp_tag,
  output logic        rsp_err
);

  state_e      state_q, state_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [2:0]  alu_f_q, alu_f_d;
  logic [3:0]  tag_q, tag_d;
  logic [31:0] rsp_y_q, rsp_y_d;
  logic        rsp_z_q, rsp_z_d;
  logic [3:0]  rsp_tag_q, rsp_tag_d;
  logic        rsp_err_q, rsp_err_d;
  // Completed-response counter, observed only by verification
  logic [15:0] op_count_q, op_count_d;

  logic [2:0]  dec_f;
  logic        dec_illegal;
  logic        accept;

  alu_op_decode u_decode (
    .op      (cmd_op),
    .f       (dec_f),
    .illegal (dec_illegal)
  );

  // A new command may enter when idle, or when the held response leaves this cycle
  assign cmd_ready = (state_q == StIdle) || ((state_q == StResp) && rsp_ready);
  assign accept    = cmd_valid && cmd_ready;

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_f     = alu_f_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_y     = rsp_y_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_err   = rsp_err_q;

  // Next-state and register-load decisions
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_f_d    = alu_f_q;
    tag_d      = tag_q;
    rsp_y_d    = rsp_y_q;
    rsp_z_d    = rsp_z_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_err_d  = rsp_err_q;
    op_count_d = op_count_q;

    unique case (state_q)
      StIdle: ;
      StExec: begin
        // ALU output is valid against the operands applied this cycle
        state_d   = StResp;
        rsp_y_d   = alu_y;
        rsp_z_d   = alu_z;
        rsp_err_d = 1'b0;
        rsp_tag_d = tag_q;
      end
      StResp: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Accept only happens in idle or a completing response, so it overrides the above
    if (accept) begin
      if (dec_illegal) begin
        // Illegal ops skip the ALU; operand registers are left untouched
        state_d   = StResp;
        rsp_y_d   = 32'd0;
        rsp_z_d   = 1'b0;
        rsp_err_d = 1'b1;
        rsp_tag_d = cmd_tag;
      end else begin
        state_d = StExec;
        alu_a_d = cmd_a;
        alu_b_d = cmd_b;
        alu_f_d = dec_f;
        tag_d   = cmd_tag;
      end
    end
  end

  // State and payload registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      alu_a_q    <= 32'd0;
      alu_b_q    <= 32'd0;
      alu_f_q    <= ALU_F_AND;
      tag_q      <= 4'd0;
      rsp_y_q    <= 32'd0;
      rsp_z_q    <= 1'b0;
      rsp_tag_q  <= 4'd0;
      rsp_err_q  <= 1'b0;
      op_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_f_q    <= alu_f_d;
      tag_q      <= tag_d;
      rsp_y_q    <= rsp_y_d;
      rsp_z_q    <= rsp_z_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_err_q  <= rsp_err_d;
      op_count_q <= op_count_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with an external behavioural ALU.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic [3:0]  cmd_tag;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_f;
  logic [31:0] alu_y;
  logic        alu_z;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_y;
  logic        rsp_z;
  logic [3:0]  rsp_tag;
  logic        rsp_err;

  typedef struct {
    logic [31:0] y;
    logic        z;
    logic [3:0]  tag;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;

  alu_cmd_issuer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_tag   (cmd_tag),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .alu_y     (alu_y),
    .alu_z     (alu_z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_z     (rsp_z),
    .rsp_tag   (rsp_tag),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // External combinational ALU
  always_comb begin
    alu_y = 32'd0;
    case (alu_f)
      ALU_F_AND: alu_y = alu_a & alu_b;
      ALU_F_OR:  alu_y = alu_a | alu_b;
      ALU_F_ADD: alu_y = alu_a + alu_b;
      ALU_F_SUB: alu_y = alu_a - alu_b;
      ALU_F_SLT: alu_y = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default:   alu_y = 32'd0;
    endcase
  end
  assign alu_z = (alu_y == 32'd0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every completed response handshake is matched against the queue
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got tag %0d, expected no response", rsp_tag);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_y", rsp_y, mon_e.y);
        check("rsp_z", {31'd0, rsp_z}, {31'd0, mon_e.z});
        check("rsp_tag", {28'd0, rsp_tag}, {28'd0, mon_e.tag});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
      end
    end
  end

  // Wait (bounded) until cmd_ready so the next posedge accepts; returns 0 on timeout
  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = cmd_ready;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got cmd_ready=0, expected 1 within 20 cycles");
    end
  endtask

  // Issue one command with rsp_ready=1 and check latency and ALU-side registers
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic [2:0] ef, input logic [31:0] ey,
                      input logic ez, input logic eerr);
    logic [2:0]  f_before;
    logic [31:0] a_before;
    bit          ok;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    exp_q.push_back('{ey, ez, tag, eerr});
    wait_ready(ok);
    if (!ok) begin
      cmd_valid = 1'b0;
      return;
    end
    f_before = alu_f;
    a_before = alu_a;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    if (eerr) begin
      check("illegal_valid_c1", {31'd0, rsp_valid}, 32'd1);
      check("illegal_alu_f_kept", {29'd0, alu_f}, {29'd0, f_before});
      check("illegal_alu_a_kept", alu_a, a_before);
    end else begin
      check("exec_valid_c1", {31'd0, rsp_valid}, 32'd0);
      check("exec_alu_f", {29'd0, alu_f}, {29'd0, ef});
      check("exec_alu_a", alu_a, a);
      check("exec_alu_b", alu_b, b);
      @(negedge clk);
      check("legal_valid_c2", {31'd0, rsp_valid}, 32'd1);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] y;
    logic        z;
    logic        err;
  } vec_t;

  vec_t burst[4];
  int   acc_cycle[4];

  initial begin
    bit ok;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_a     = 32'd0;
    cmd_b     = 32'd0;
    cmd_tag   = 4'd0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_alu_a", alu_a, 32'd0);
    check("reset_alu_b", alu_b, 32'd0);
    check("reset_alu_f", {29'd0, alu_f}, 32'd0);
    check("reset_rsp_y", rsp_y, 32'd0);
    check("reset_rsp_tag", {28'd0, rsp_tag}, 32'd0);
    check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("reset_op_count", {16'd0, dut.op_count_q}, 32'd0);

    // Directed single commands
    send(OP_ADD, 32'd5, 32'd7, 4'd3, 3'b010, 32'd12, 1'b0, 1'b0);
    send(OP_SUB, 32'd9, 32'd9, 4'd4, 3'b110, 32'd0, 1'b1, 1'b0);
    send(OP_AND, 32'hFF00FF00, 32'h0FF00FF0, 4'd6, 3'b000, 32'h0F000F00, 1'b0, 1'b0);
    send(OP_SLT, 32'hFFFFFFFF, 32'd1, 4'd5, 3'b111, 32'd1, 1'b0, 1'b0);
    send(3'd5, 32'd123, 32'd456, 4'd7, 3'b111, 32'd0, 1'b0, 1'b1);
    send(OP_ADD, 32'h10, 32'h20, 4'd8, 3'b010, 32'h30, 1'b0, 1'b0);

    // Back-to-back burst with cmd_valid held: legal gap 2 cycles, illegal gap 1
    burst[0] = '{OP_OR, 32'd1, 32'd2, 4'd9, 32'd3, 1'b0, 1'b0};
    burst[1] = '{OP_ADD, 32'hFFFFFFFF, 32'd1, 4'd10, 32'd0, 1'b1, 1'b0};
    burst[2] = '{3'd6, 32'd1, 32'd1, 4'd11, 32'd0, 1'b0, 1'b1};
    burst[3] = '{OP_SUB, 32'd3, 32'd5, 4'd12, 32'hFFFFFFFE, 1'b0, 1'b0};
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = burst[i].op;
      cmd_a     = burst[i].a;
      cmd_b     = burst[i].b;
      cmd_tag   = burst[i].tag;
      exp_q.push_back('{burst[i].y, burst[i].z, burst[i].tag, burst[i].err});
      wait_ready(ok);
      acc_cycle[i] = cycle;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("gap_or_add", 32'(acc_cycle[1] - acc_cycle[0]), 32'd2);
    check("gap_add_ill", 32'(acc_cycle[2] - acc_cycle[1]), 32'd2);
    check("gap_ill_sub", 32'(acc_cycle[3] - acc_cycle[2]), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("op_count_10", {16'd0, dut.op_count_q}, 32'd10);

    // Backpressure: response held 5 cycles, then simultaneous rsp and cmd handshakes
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_AND;
    cmd_a     = 32'hFF00FF00;
    cmd_b     = 32'h0FF00FF0;
    cmd_tag   = 4'd13;
    exp_q.push_back('{32'h0F000F00, 1'b0, 4'd13, 1'b0});
    wait_ready(ok);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("hold_rsp_y", rsp_y, 32'h0F000F00);
      check("hold_rsp_tag", {28'd0, rsp_tag}, 32'd13);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = OP_OR;
    cmd_a     = 32'hF0;
    cmd_b     = 32'h0F;
    cmd_tag   = 4'd14;
    exp_q.push_back('{32'hFF, 1'b0, 4'd14, 1'b0});
    @(negedge clk);
    check("dual_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("dual_op_count", {16'd0, dut.op_count_q}, 32'd11);
    @(negedge clk);
    check("dual_exec_alu_f", {29'd0, alu_f}, 32'b001);
    repeat (3) @(posedge clk);
    #1;
    check("op_count_12", {16'd0, dut.op_count_q}, 32'd12);

    // Reset during EXEC abandons the command
    cmd_valid = 1'b1;
    cmd_op    = OP_ADD;
    cmd_a     = 32'd1;
    cmd_b     = 32'd1;
    cmd_tag   = 4'd15;
    wait_ready(ok);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_exec_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_exec_op_count", {16'd0, dut.op_count_q}, 32'd0);
    check("rst_exec_alu_f", {29'd0, alu_f}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("rst_exec_no_rsp", {31'd0, rsp_valid}, 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
